cbu_mod_counter: RTL

- Cascadable N-bit up counter with synchronous clear, synchronous preset, parallel load, enable, CAI and CAO.
- Counts up toward a programmable terminal value (LIM), then wraps to zero.
- It is the count-up companion to the 4-bit down-counter macro in the same behavioural macro library.
- Used in divider, timer and address-generation chains; instances cascade through CAO to the next stage's CAI.

---
 rtl/cbu_mod_counter_pkg.sv | 27 ++
 rtl/cbu_mod_counter_if.sv | 28 ++
 rtl/cbu_mod_counter_tc_cmp.sv | 11 +
 rtl/cbu_mod_counter.sv | 71 +++++++
 4 files changed

// File: rtl/cbu_mod_counter_pkg.sv
// Shared definitions for the cbu counter macros: operation encoding, default width
// and the priority decoder that selects one operation per clock edge.
package cbu_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_PRESET,
    OP_LOAD,
    OP_COUNT
  } cnt_op_t;

  localparam int unsigned CBU_WIDTH_DEF = 4;

  // Fixed priority: clear > preset > load > count > hold.
  function automatic cnt_op_t sel_op(input logic cd, input logic ps, input logic ld,
                                     input logic cai, input logic en);
    cnt_op_t op;
    if (cd)             op = OP_CLEAR;
    else if (ps)        op = OP_PRESET;
    else if (ld)        op = OP_LOAD;
    else if (cai && en) op = OP_COUNT;
    else                op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/cbu_mod_counter_if.sv
// Control/data bundle of one counter stage; master is the driving side, slave the counter.
interface cbu_mod_counter_if
  import cbu_pkg::*;
#(
  parameter int WIDTH = CBU_WIDTH_DEF
);
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] LIM;
  logic             CAI;
  logic             EN;
  logic             LD;
  logic             PS;
  logic             OVF_CLR;
  logic [WIDTH-1:0] Q;
  logic             CAO;
  logic             TC;
  logic             OVF;

  modport master (
    output D, LIM, CAI, EN, LD, PS, OVF_CLR,
    input  Q, CAO, TC, OVF
  );

  modport slave (
    input  D, LIM, CAI, EN, LD, PS, OVF_CLR,
    output Q, CAO, TC, OVF
  );
endinterface

// File: rtl/cbu_mod_counter_tc_cmp.sv
// Unsigned terminal-count compare; shared by the carry-out and the wrap decision
// so both always agree on when the stage is at or past its limit.
module cbu_tc_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] lim,
  output logic             at_tc
);
  assign at_tc = (q >= lim);
endmodule

// File: rtl/cbu_mod_counter.sv
// Cascadable modulo up counter: counts to LIM then wraps to zero, with preset,
// parallel load, a one-cycle wrap pulse (TC) and a sticky overflow flag (OVF).
module cbu_mod_counter
  import cbu_pkg::*;
#(
  parameter int WIDTH  = CBU_WIDTH_DEF,
  parameter bit OVF_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              CD,
  cbu_mod_counter_if.slave  bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_tc;
  logic             wrap;
  cnt_op_t          op;

  cbu_tc_cmp #(.WIDTH(WIDTH)) u_tc_cmp (
    .q     (q_q),
    .lim   (bus.LIM),
    .at_tc (at_tc)
  );

  assign op   = sel_op(CD, bus.PS, bus.LD, bus.CAI, bus.EN);
  assign wrap = (op == OP_COUNT) && at_tc;

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    unique case (op)
      OP_CLEAR: begin
        q_d   = '0;
        ovf_d = 1'b0;
      end
      OP_PRESET: q_d = '1;
      OP_LOAD:   q_d = bus.D;
      OP_COUNT:  q_d = at_tc ? '0 : q_q + WIDTH'(1);
      default:   q_d = q_q;
    endcase
    if (op != OP_CLEAR) begin
      // A wrap in the same cycle as a clear request keeps the flag set.
      if (wrap)             ovf_d = 1'b1;
      else if (bus.OVF_CLR) ovf_d = 1'b0;
    end
    tc_d = wrap;
    if (!OVF_EN) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (CD) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  // Carry-out ignores PS/LD so a downstream stage may count while this one loads.
  assign bus.CAO = bus.CAI & bus.EN & at_tc;
  assign bus.Q   = q_q;
  assign bus.TC  = tc_q;
  assign bus.OVF = OVF_EN ? ovf_q : 1'b0;

endmodule
